// File: rtl/oq_sram_responder.sv
// Write/read port arbiter in front of a pipelined synchronous SRAM.
// Optional word parity is enabled with OQ_SRAM_PARITY_EN.
module oq_sram_responder #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH/8,
   parameter int SRAM_ADDR_WIDTH = 19,
   parameter int SRAM_RD_LATENCY = 2,
   parameter int TURNAROUND      = 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [SRAM_ADDR_WIDTH-1:0]            wr_0_addr,
   input  logic                                  wr_0_req,
   output logic                                  wr_0_ack,
   input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]      wr_0_data,
   input  logic [SRAM_ADDR_WIDTH-1:0]            rd_0_addr,
   input  logic                                  rd_0_req,
   output logic                                  rd_0_ack,
   output logic [DATA_WIDTH+CTRL_WIDTH-1:0]      rd_0_data,
   output logic                                  rd_0_vld,
   output logic [SRAM_ADDR_WIDTH-1:0]            sram_addr,
   output logic                                  sram_wr_en,
   output logic                                  sram_rd_en,
   output logic [DATA_WIDTH+CTRL_WIDTH:0]        sram_wr_data,
   input  logic [DATA_WIDTH+CTRL_WIDTH:0]        sram_rd_data,
   output logic                                  rd_parity_err
);

   localparam int W = DATA_WIDTH + CTRL_WIDTH;
   localparam int L = SRAM_RD_LATENCY;
   localparam bit TA = (TURNAROUND != 0);

   logic         last_rd;
   logic         prev_wr;
   logic         prev_rd;
   logic         blk_wr;
   logic         blk_rd;
   logic         gnt_wr;
   logic         gnt_rd;
   logic [L:0]   vld_pipe;
   logic [L+1:0] vtap;
   logic         par_bit;
   logic         rd_chk;

`ifdef OQ_SRAM_PARITY_EN
   assign par_bit = ^wr_0_data;
   assign rd_chk  = ^sram_rd_data;
`else
   logic rd_msb_unused;
   assign par_bit       = 1'b0;
   assign rd_chk        = 1'b0;
   assign rd_msb_unused = sram_rd_data[W];
`endif

   // A direction switch right after a grant is held off one cycle;
   // on contention the round-robin loser waits rather than jumping ahead.
   always_comb begin
      blk_wr = TA && prev_rd;
      blk_rd = TA && prev_wr;
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      if (!reset) begin
         if (wr_0_req && rd_0_req) begin
            if (last_rd) gnt_wr = !blk_wr;
            else         gnt_rd = !blk_rd;
         end else begin
            gnt_wr = wr_0_req && !blk_wr;
            gnt_rd = rd_0_req && !blk_rd;
         end
      end
   end

   assign wr_0_ack = gnt_wr;
   assign rd_0_ack = gnt_rd;

   assign vtap     = {vld_pipe, sram_rd_en};
   assign rd_0_vld = vld_pipe[L];

   always_ff @(posedge clk) begin
      if (reset) begin
         last_rd       <= 1'b0;
         prev_wr       <= 1'b0;
         prev_rd       <= 1'b0;
         sram_addr     <= '0;
         sram_wr_en    <= 1'b0;
         sram_rd_en    <= 1'b0;
         sram_wr_data  <= '0;
         vld_pipe      <= '0;
         rd_0_data     <= '0;
         rd_parity_err <= 1'b0;
      end else begin
         prev_wr    <= gnt_wr;
         prev_rd    <= gnt_rd;
         sram_wr_en <= gnt_wr;
         sram_rd_en <= gnt_rd;
         if (gnt_wr || gnt_rd) last_rd <= gnt_rd;
         if (gnt_wr) begin
            sram_addr    <= wr_0_addr;
            sram_wr_data <= {par_bit, wr_0_data};
         end else if (gnt_rd) begin
            sram_addr <= rd_0_addr;
         end
         // vtap[L] marks the cycle the SRAM presents the read word
         vld_pipe <= vtap[L:0];
         if (vtap[L]) rd_0_data <= sram_rd_data[W-1:0];
         rd_parity_err <= vtap[L] && rd_chk;
      end
   end

endmodule

// File: tb/tb_oq_sram_responder.sv
// Directed bench for oq_sram_responder with a 2-cycle SRAM model.
// Honors OQ_SRAM_PARITY_EN for the parity expectations.
module tb_oq_sram_responder;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int AW = 19;
   localparam int W  = DW + CW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] rd_addr = '0;
   logic          wr_req = 1'b0;
   logic          rd_req = 1'b0;
   logic [W-1:0]  wr_data = '0;

   logic          wr_ack, rd_ack, rd_vld, par_err;
   logic [W-1:0]  rd_data;
   logic [AW-1:0] s_addr;
   logic          s_we, s_re;
   logic [W:0]    s_wd, s_rd;

   logic          wr_ack_b, rd_ack_b, rd_vld_b, par_err_b;
   logic [W-1:0]  rd_data_b;
   logic [AW-1:0] s_addr_b;
   logic          s_we_b, s_re_b;
   logic [W:0]    s_wd_b;
   logic [W:0]    s_rd_b;

   int total = 0;
   int bad = 0;

   logic [W:0] mem [0:255];
   logic [W:0] s1, s2;
   logic       flip = 1'b0;

   always #5 clk = ~clk;

   oq_sram_responder #(.TURNAROUND(1)) dut (
      .clk(clk), .reset(reset),
      .wr_0_addr(wr_addr), .wr_0_req(wr_req), .wr_0_ack(wr_ack),
      .wr_0_data(wr_data),
      .rd_0_addr(rd_addr), .rd_0_req(rd_req), .rd_0_ack(rd_ack),
      .rd_0_data(rd_data), .rd_0_vld(rd_vld),
      .sram_addr(s_addr), .sram_wr_en(s_we), .sram_rd_en(s_re),
      .sram_wr_data(s_wd), .sram_rd_data(s_rd),
      .rd_parity_err(par_err)
   );

   oq_sram_responder #(.TURNAROUND(0)) dut0 (
      .clk(clk), .reset(reset),
      .wr_0_addr(wr_addr), .wr_0_req(wr_req), .wr_0_ack(wr_ack_b),
      .wr_0_data(wr_data),
      .rd_0_addr(rd_addr), .rd_0_req(rd_req), .rd_0_ack(rd_ack_b),
      .rd_0_data(rd_data_b), .rd_0_vld(rd_vld_b),
      .sram_addr(s_addr_b), .sram_wr_en(s_we_b), .sram_rd_en(s_re_b),
      .sram_wr_data(s_wd_b), .sram_rd_data(s_rd_b),
      .rd_parity_err(par_err_b)
   );

   assign s_rd_b = '0;

   // SRAM model: two register stages from strobe to data
   initial for (int i = 0; i < 256; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (s_we) mem[s_addr[7:0]] <= s_wd;
      s1 <= s_re ? (mem[s_addr[7:0]] ^ (flip ? 73'h20 : 73'h0)) : '0;
      s2 <= s1;
   end
   assign s_rd = s2;

   function automatic logic exp_par(input logic [W-1:0] d);
`ifdef OQ_SRAM_PARITY_EN
      return ^d;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [W-1:0] wdat(input int i);
      return {8'hff, 64'h5555_5555_5555_5555 + 64'(i)};
   endfunction

   task automatic test_reset;
      reset = 1'b1;
      wr_req = 1'b1;
      rd_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL rst_wr_ack got=%b exp=0", wr_ack); end
      total++; if (rd_ack !== 1'b0) begin bad++; $display("FAIL rst_rd_ack got=%b exp=0", rd_ack); end
      total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL rst_rd_vld got=%b exp=0", rd_vld); end
      total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
      total++; if (s_we !== 1'b0) begin bad++; $display("FAIL rst_sram_wr_en got=%b exp=0", s_we); end
      total++; if (s_re !== 1'b0) begin bad++; $display("FAIL rst_sram_rd_en got=%b exp=0", s_re); end
      total++; if (s_addr !== '0) begin bad++; $display("FAIL rst_sram_addr got=%h exp=0", s_addr); end
      total++; if (s_wd !== '0) begin bad++; $display("FAIL rst_sram_wr_data got=%h exp=0", s_wd); end
      total++; if (par_err !== 1'b0) begin bad++; $display("FAIL rst_par_err got=%b exp=0", par_err); end
      wr_req = 1'b0;
      rd_req = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_write_only;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            total++; if (s_we !== 1'b1) begin bad++; $display("FAIL wr_strobe%0d got=%b exp=1", i-1, s_we); end
            total++; if (s_re !== 1'b0) begin bad++; $display("FAIL wr_no_rd%0d got=%b exp=0", i-1, s_re); end
            total++; if (s_addr !== AW'(32'h10 + i - 1)) begin bad++; $display("FAIL wr_addr%0d got=%h exp=%h", i-1, s_addr, 32'h10 + i - 1); end
            total++; if (s_wd !== {exp_par(wdat(i-1)), wdat(i-1)}) begin bad++; $display("FAIL wr_data%0d got=%h exp=%h", i-1, s_wd, {exp_par(wdat(i-1)), wdat(i-1)}); end
         end
         if (i < 4) begin
            wr_req = 1'b1;
            wr_addr = AW'(32'h10 + i);
            wr_data = wdat(i);
            #1;
            total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack%0d got=%b exp=1", i, wr_ack); end
            total++; if (rd_ack !== 1'b0) begin bad++; $display("FAIL wr_rdack%0d got=%b exp=0", i, rd_ack); end
         end else begin
            wr_req = 1'b0;
         end
      end
      @(negedge clk);
      total++; if (s_we !== 1'b0) begin bad++; $display("FAIL wr_idle_en got=%b exp=0", s_we); end
      total++; if (s_addr !== AW'(32'h13)) begin bad++; $display("FAIL wr_idle_addr got=%h exp=13", s_addr); end
   endtask

   task automatic test_read_latency;
      @(negedge clk);
      rd_req = 1'b1;
      rd_addr = AW'(32'h10);
      #1;
      total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL lat_ack got=%b exp=1", rd_ack); end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin
            rd_req = 1'b0;
            total++; if (s_re !== 1'b1) begin bad++; $display("FAIL lat_rd_en got=%b exp=1", s_re); end
            total++; if (s_addr !== AW'(32'h10)) begin bad++; $display("FAIL lat_addr got=%h exp=10", s_addr); end
         end
         total++; if (rd_vld !== (k == 4)) begin bad++; $display("FAIL lat_vld_n+%0d got=%b exp=%b", k, rd_vld, k == 4); end
         if (k == 4) begin
            total++; if (rd_data !== wdat(0)) begin bad++; $display("FAIL lat_data got=%h exp=%h", rd_data, wdat(0)); end
            total++; if (par_err !== 1'b0) begin bad++; $display("FAIL lat_par got=%b exp=0", par_err); end
         end
      end
   endtask

   task automatic test_wr_then_rd;
      logic         got;
      logic [W-1:0] d;
      d = 72'hA5_0123_4567_89AB_CDEF;
      @(negedge clk);
      wr_req = 1'b1; wr_addr = AW'(32'h20); wr_data = d;
      rd_req = 1'b1; rd_addr = AW'(32'h20);
      #1;
      total++; if ({wr_ack, rd_ack} !== 2'b10) begin bad++; $display("FAIL rr_first got=%b exp=10", {wr_ack, rd_ack}); end
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      total++; if (rd_ack !== 1'b0) begin bad++; $display("FAIL rr_turnaround got=%b exp=0", rd_ack); end
      @(negedge clk);
      #1;
      total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL rr_rd_ack got=%b exp=1", rd_ack); end
      @(negedge clk);
      rd_req = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (rd_vld) got = 1'b1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL rr_vld_timeout got=0 exp=1"); end
      else if (rd_data !== d) begin bad++; $display("FAIL rr_data got=%h exp=%h", rd_data, d); end
   endtask

   task automatic test_contention;
      logic er, ew, er0, ew0;
      @(negedge clk);
      reset = 1'b1;
      wr_req = 1'b1; wr_addr = AW'(32'h40); wr_data = 72'h11_2222_3333_4444_5555;
      rd_req = 1'b1; rd_addr = AW'(32'h10);
      @(negedge clk);
      total++; if ({wr_ack, rd_ack, wr_ack_b, rd_ack_b} !== 4'b0) begin bad++; $display("FAIL ct_reset_acks got=%b exp=0000", {wr_ack, rd_ack, wr_ack_b, rd_ack_b}); end
      reset = 1'b0;
      for (int j = 0; j < 8; j++) begin
         #1;
         er  = (j % 4 == 0);
         ew  = (j % 4 == 2);
         er0 = (j % 2 == 0);
         ew0 = (j % 2 == 1);
         total++; if ({wr_ack, rd_ack} !== {ew, er}) begin bad++; $display("FAIL ct_ta1_c%0d got=%b exp=%b", j, {wr_ack, rd_ack}, {ew, er}); end
         total++; if ({wr_ack_b, rd_ack_b} !== {ew0, er0}) begin bad++; $display("FAIL ct_ta0_c%0d got=%b exp=%b", j, {wr_ack_b, rd_ack_b}, {ew0, er0}); end
         if (j > 0) begin
            total++; if ({s_we_b, s_re_b} !== {ew0 ? 1'b0 : 1'b1, ew0}) begin bad++; $display("FAIL ct_ta0_strb%0d got=%b exp=%b", j, {s_we_b, s_re_b}, {~ew0, ew0}); end
         end
         @(negedge clk);
      end
      wr_req = 1'b0;
      rd_req = 1'b0;
   endtask

   task automatic test_reset_mid_read;
      repeat (8) @(negedge clk);
      rd_req = 1'b1;
      rd_addr = AW'(32'h11);
      #1;
      total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL mr_ack0 got=%b exp=1", rd_ack); end
      @(negedge clk);
      #1;
      total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL mr_ack1 got=%b exp=1", rd_ack); end
      @(negedge clk);
      rd_req = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      total++; if ({s_we, s_re, rd_vld, par_err} !== 4'b0) begin bad++; $display("FAIL mr_rst_strb got=%b exp=0000", {s_we, s_re, rd_vld, par_err}); end
      total++; if (s_addr !== '0 || s_wd !== '0) begin bad++; $display("FAIL mr_rst_bus got=%h/%h exp=0/0", s_addr, s_wd); end
      total++; if (rd_data !== '0) begin bad++; $display("FAIL mr_rst_data got=%h exp=0", rd_data); end
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL mr_vld_after%0d got=%b exp=0", k, rd_vld); end
      end
   endtask

   task automatic test_parity;
      logic         got;
      logic [W-1:0] d;
      logic [W-1:0] ed;
      logic         ep;
      d = 72'h01_0000_0000_0000_0007;
      @(negedge clk);
      wr_req = 1'b1; wr_addr = AW'(32'h30); wr_data = d;
      #1;
      total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL par_wr_ack got=%b exp=1", wr_ack); end
      @(negedge clk);
      wr_req = 1'b0;
      total++; if (s_wd[W] !== exp_par(d)) begin bad++; $display("FAIL par_wr_msb got=%b exp=%b", s_wd[W], exp_par(d)); end
      for (int f = 0; f < 2; f++) begin
         @(negedge clk);
         flip = (f == 1);
         rd_req = 1'b1; rd_addr = AW'(32'h30);
         #1;
         total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL par_rd_ack%0d got=%b exp=1", f, rd_ack); end
         @(negedge clk);
         rd_req = 1'b0;
         got = 1'b0;
         for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (rd_vld) got = 1'b1;
         end
         ed = (f == 1) ? (d ^ 72'h20) : d;
`ifdef OQ_SRAM_PARITY_EN
         ep = (f == 1);
`else
         ep = 1'b0;
`endif
         total++;
         if (!got) begin bad++; $display("FAIL par_vld_timeout%0d got=0 exp=1", f); end
         else if (rd_data !== ed) begin bad++; $display("FAIL par_data%0d got=%h exp=%h", f, rd_data, ed); end
         total++; if (par_err !== ep) begin bad++; $display("FAIL par_err%0d got=%b exp=%b", f, par_err, ep); end
         @(negedge clk);
         total++; if (par_err !== 1'b0) begin bad++; $display("FAIL par_err_pulse%0d got=%b exp=0", f, par_err); end
         flip = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_write_only();
      test_read_latency();
      test_wr_then_rd();
      test_contention();
      test_reset_mid_read();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oq_sram_responder.md
OQ_SRAM_RESPONDER -- requirements
Module: oq_sram_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, packet data word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control byte-mask width.
REQ-003 SHALL have parameter SRAM_ADDR_WIDTH, default 19, word address width.
REQ-004 SHALL have parameter SRAM_RD_LATENCY, default 2, cycles from sram_addr/sram_rd_en to sram_rd_data.
REQ-005 SHALL have parameter TURNAROUND, default 1 (0 or 1), idle SRAM cycles inserted on direction change.
REQ-006 SHALL have one clock and one reset: clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-007 wr_0_addr  in  SRAM_ADDR_WIDTH  write address; wr_0_req  in  1  write request; wr_0_ack  out  1  write accepted; wr_0_data  in  DATA_WIDTH+CTRL_WIDTH  {ctrl,data} write word.
REQ-008 rd_0_addr  in  SRAM_ADDR_WIDTH  read address; rd_0_req  in  1  read request; rd_0_ack  out  1  read accepted; rd_0_data  out  DATA_WIDTH+CTRL_WIDTH  read word; rd_0_vld  out  1  rd_0_data valid.
REQ-009 sram_addr  out  SRAM_ADDR_WIDTH; sram_wr_en  out  1; sram_rd_en  out  1; sram_wr_data  out  DATA_WIDTH+CTRL_WIDTH+1 (MSB parity); sram_rd_data  in  DATA_WIDTH+CTRL_WIDTH+1.
REQ-010 rd_parity_err  out  1  parity mismatch on returned read word.

Function
REQ-011 Requester SHALL hold req, addr, data stable until ack; each cycle with req&ack high transfers exactly one word; req held after ack is a new request.
REQ-012 wr_0_ack/rd_0_ack SHALL be combinational from req and registered arbiter state; at most one ack high per cycle.
REQ-013 Arbiter SHALL grant the sole requester when only one requests, subject to REQ-015.
REQ-014 When both request and neither is blocked, grant SHALL go to the direction not granted most recently (round robin).
REQ-015 If TURNAROUND=1 and the previous cycle granted direction X, direction Y≠X SHALL NOT be granted this cycle; X may still be granted.
REQ-016 Granted access SHALL appear on sram_addr/sram_wr_en/sram_rd_en/sram_wr_data registered one cycle after ack; strobes are single-cycle; sram_wr_en and sram_rd_en never both high.
REQ-017 Idle SRAM cycles SHALL drive sram_wr_en=sram_rd_en=0; sram_addr/sram_wr_data hold last value.
REQ-018 Read issued at cycle T SHALL return via registered rd_0_data with one-cycle rd_0_vld pulse at T+SRAM_RD_LATENCY+1 (ack at N => vld at N+SRAM_RD_LATENCY+2).
REQ-019 Read returns SHALL be in issue order; back-to-back reads yield back-to-back vld pulses; no backpressure on read data.
REQ-020 Valid tracking SHALL be a SRAM_RD_LATENCY+1 stage shift pipeline; no other read buffering.
REQ-021 Write followed by read to same address, both acked, SHALL return the written data (SRAM write-then-read ordering, no forwarding required).

Reset
REQ-022 On reset: wr_0_ack=0, rd_0_ack=0, rd_0_vld=0, rd_0_data=0, sram_wr_en=0, sram_rd_en=0, sram_addr=0, sram_wr_data=0, rd_parity_err=0.
REQ-023 Reset SHALL clear the read-valid pipeline; reads in flight produce no rd_0_vld.
REQ-024 Reset SHALL set last-granted=write and clear the turnaround block, so first contention grants read.
REQ-025 Acks SHALL be 0 during the reset cycle.

Configuration
REQ-026 Macro OQ_SRAM_PARITY_EN defined: sram_wr_data MSB = even parity (XOR) over {ctrl,data}; on each rd_0_vld, rd_parity_err pulses with it if returned parity mismatches; rd_0_data delivered regardless.
REQ-027 Macro OQ_SRAM_PARITY_EN undefined: sram_wr_data MSB=0, sram_rd_data MSB ignored, rd_parity_err tied 0.

Verification
REQ-028 Write-only: wr_0_req held with addr 0x00010, data 0x55..., 4 words incrementing addr -> ack every cycle, sram_wr_en 4 consecutive cycles one cycle after each ack.
REQ-029 Read latency: single rd_0_req addr 0x00010 after above writes, ack at cycle N -> rd_0_vld at N+4 (default latency) with matching data, one cycle.
REQ-030 Contention, TURNAROUND=1: both req held continuously from reset -> grant sequence R, bubble, W, bubble, R...; no cycle with both acks.
REQ-031 Contention, TURNAROUND=0: both held -> R, W, R, W every cycle, sram strobes every cycle alternating.
REQ-032 Reset mid-read: 2 reads acked, reset asserted next cycle for 1 cycle -> no rd_0_vld afterwards, all outputs 0 during reset.
REQ-033 OQ_SRAM_PARITY_EN defined: model flips bit 5 of returned word -> rd_parity_err pulses coincident with rd_0_vld; unflipped reads -> 0.
